// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle NotRISC control unit: fetch/decode/execute sequencing with data-memory wait states.
// Optional conditional relative branch (JPZ) is built only when CU_JPZ_EN is defined.
module cpu_ctrl_fsm #(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 4,
  parameter int unsigned RAW = 4,
  parameter int unsigned DAW = 8,
  parameter int unsigned ASW = 3
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [IW-1:0]  INSTR,
  input  logic           MEM_RDY,
  input  logic           RF_RA_ZERO,
  output logic           PC_CLR,
  output logic           PC_LD,
  output logic           PC_INC,
  output logic [DAW-1:0] PC_OFFSET,
  output logic [DAW-1:0] D_ADDR,
  output logic           D_RD,
  output logic           D_WR,
  output logic           RF_S,
  output logic           RF_W_EN,
  output logic [RAW-1:0] RF_RA_ADDR,
  output logic [RAW-1:0] RF_RB_ADDR,
  output logic [RAW-1:0] RF_W_ADDR,
  output logic [ASW-1:0] ALU_S,
  output logic           HALTED
);

  if ((OPW + DAW + RAW > IW) || (OPW + 3 * RAW > IW)) begin : g_bad_widths
    $error("cpu_ctrl_fsm: instruction fields do not fit in IW");
  end

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(1);
  localparam logic [OPW-1:0] OP_STORE = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_AND   = OPW'(5);
  localparam logic [OPW-1:0] OP_OR    = OPW'(6);
`ifdef CU_JPZ_EN
  localparam logic [OPW-1:0] OP_JPZ   = OPW'(7);
`endif
  localparam logic [OPW-1:0] OP_HALT  = '1;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD_A,
    S_LOAD_B,
    S_STORE,
    S_ALU,
    S_HALT
`ifdef CU_JPZ_EN
    , S_JUMP
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic           armed_q, armed_d;

  logic           pc_clr_q, pc_clr_d;
  logic           pc_inc_q, pc_inc_d;
  logic [DAW-1:0] d_addr_q, d_addr_d;
  logic           d_rd_q, d_rd_d;
  logic           d_wr_q, d_wr_d;
  logic           rf_s_q, rf_s_d;
  logic           rf_w_en_q, rf_w_en_d;
  logic [RAW-1:0] ra_q, ra_d;
  logic [RAW-1:0] rb_q, rb_d;
  logic [RAW-1:0] wa_q, wa_d;
  logic [ASW-1:0] alu_s_q, alu_s_d;
  logic           halted_q, halted_d;
`ifdef CU_JPZ_EN
  logic           jump_q, jump_d;
  logic [DAW-1:0] pc_off_q, pc_off_d;
`endif

  logic [OPW-1:0] op_q, op_d;
  logic [RAW-1:0] ra_f, rb_f, lo_f;
  logic [DAW-1:0] addr_f;

  function automatic logic [ASW-1:0] alu_sel(input logic [OPW-1:0] op);
    case (op)
      OP_ADD:  return ASW'(1);
      OP_SUB:  return ASW'(2);
      OP_AND:  return ASW'(3);
      OP_OR:   return ASW'(4);
      default: return '0;
    endcase
  endfunction

  assign op_q = ir_q[IW-1 -: OPW];

  // armed_q delays the INIT->FETCH step by one edge after reset release
  always_comb begin
    armed_d = 1'b1;
    ir_d    = (state_q == S_FETCH) ? INSTR : ir_q;
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = armed_q ? S_FETCH : S_INIT;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op_q == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          case (op_q)
            OP_LOAD:                       state_d = S_LOAD_A;
            OP_STORE:                      state_d = S_STORE;
            OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_ALU;
`ifdef CU_JPZ_EN
            OP_JPZ:                        state_d = S_JUMP;
`endif
            default:                       state_d = S_FETCH;
          endcase
        end
      end
      S_LOAD_A: state_d = MEM_RDY ? S_LOAD_B : S_LOAD_A;
      S_LOAD_B: state_d = S_FETCH;
      S_STORE:  state_d = MEM_RDY ? S_FETCH : S_STORE;
      S_ALU:    state_d = S_FETCH;
`ifdef CU_JPZ_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Outputs are decoded from the next state and next IR so the registered
  // copies line up with the state they belong to.
  assign op_d   = ir_d[IW-1 -: OPW];
  assign ra_f   = ir_d[IW-OPW-1 -: RAW];
  assign rb_f   = ir_d[IW-OPW-RAW-1 -: RAW];
  assign lo_f   = ir_d[RAW-1:0];
  assign addr_f = ir_d[RAW +: DAW];

  always_comb begin
    pc_clr_d  = 1'b0;
    pc_inc_d  = 1'b0;
    d_addr_d  = '0;
    d_rd_d    = 1'b0;
    d_wr_d    = 1'b0;
    rf_s_d    = 1'b0;
    rf_w_en_d = 1'b0;
    ra_d      = '0;
    rb_d      = '0;
    wa_d      = '0;
    alu_s_d   = '0;
    halted_d  = 1'b0;
`ifdef CU_JPZ_EN
    jump_d    = 1'b0;
    pc_off_d  = '0;
`endif
    case (state_d)
      S_INIT:   pc_clr_d = 1'b1;
      S_FETCH:  pc_inc_d = 1'b1;
      S_DECODE: begin
        ra_d = ra_f;
        rb_d = rb_f;
      end
      S_LOAD_A: begin
        d_rd_d   = 1'b1;
        d_addr_d = addr_f;
      end
      S_LOAD_B: begin
        rf_s_d    = 1'b1;
        rf_w_en_d = 1'b1;
        wa_d      = lo_f;
      end
      S_STORE: begin
        d_wr_d   = 1'b1;
        d_addr_d = addr_f;
        ra_d     = lo_f;
      end
      S_ALU: begin
        rf_w_en_d = 1'b1;
        wa_d      = lo_f;
        alu_s_d   = alu_sel(op_d);
      end
`ifdef CU_JPZ_EN
      S_JUMP: begin
        ra_d     = ra_f;
        pc_off_d = ir_d[DAW-1:0];
        jump_d   = 1'b1;
      end
`endif
      S_HALT:   halted_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_INIT;
      ir_q      <= '0;
      armed_q   <= 1'b0;
      pc_clr_q  <= 1'b1;
      pc_inc_q  <= 1'b0;
      d_addr_q  <= '0;
      d_rd_q    <= 1'b0;
      d_wr_q    <= 1'b0;
      rf_s_q    <= 1'b0;
      rf_w_en_q <= 1'b0;
      ra_q      <= '0;
      rb_q      <= '0;
      wa_q      <= '0;
      alu_s_q   <= '0;
      halted_q  <= 1'b0;
`ifdef CU_JPZ_EN
      jump_q    <= 1'b0;
      pc_off_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      armed_q   <= armed_d;
      pc_clr_q  <= pc_clr_d;
      pc_inc_q  <= pc_inc_d;
      d_addr_q  <= d_addr_d;
      d_rd_q    <= d_rd_d;
      d_wr_q    <= d_wr_d;
      rf_s_q    <= rf_s_d;
      rf_w_en_q <= rf_w_en_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      wa_q      <= wa_d;
      alu_s_q   <= alu_s_d;
      halted_q  <= halted_d;
`ifdef CU_JPZ_EN
      jump_q    <= jump_d;
      pc_off_q  <= pc_off_d;
`endif
    end
  end

  assign PC_CLR     = pc_clr_q;
  assign PC_INC     = pc_inc_q;
  assign D_ADDR     = d_addr_q;
  assign D_RD       = d_rd_q;
  assign D_WR       = d_wr_q;
  assign RF_S       = rf_s_q;
  assign RF_W_EN    = rf_w_en_q;
  assign RF_RA_ADDR = ra_q;
  assign RF_RB_ADDR = rb_q;
  assign RF_W_ADDR  = wa_q;
  assign ALU_S      = alu_s_q;
  assign HALTED     = halted_q;

`ifdef CU_JPZ_EN
  // RF_RA_ZERO reflects ra only while JUMP drives RF_RA_ADDR, so it gates the load directly
  assign PC_LD     = jump_q & RF_RA_ZERO;
  assign PC_OFFSET = pc_off_q;
`else
  logic unused_rf_ra_zero;
  assign unused_rf_ra_zero = RF_RA_ZERO;
  assign PC_LD     = 1'b0;
  assign PC_OFFSET = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed instruction vectors, per-cycle expected outputs
// queued by the stimulus and popped by an independent monitor.
module tb_cpu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        mem_rdy;
  logic        ra_zero;

  logic        pc_clr, pc_ld, pc_inc, d_rd, d_wr, rf_s, rf_w_en, halted;
  logic [7:0]  pc_off, d_addr;
  logic [3:0]  ra_addr, rb_addr, w_addr;
  logic [2:0]  alu_s;

  typedef struct packed {
    logic       pc_clr;
    logic       pc_ld;
    logic       pc_inc;
    logic [7:0] pc_off;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic       rf_s;
    logic       rf_w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] wa;
    logic [2:0] alu_s;
    logic       halted;
  } out_t;

  out_t  act;
  out_t  exp_q[$];
  string nm_q[$];
  int    total = 0;
  int    bad   = 0;

  cpu_ctrl_fsm #(.IW(16), .OPW(4), .RAW(4), .DAW(8), .ASW(3)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .INSTR      (instr),
    .MEM_RDY    (mem_rdy),
    .RF_RA_ZERO (ra_zero),
    .PC_CLR     (pc_clr),
    .PC_LD      (pc_ld),
    .PC_INC     (pc_inc),
    .PC_OFFSET  (pc_off),
    .D_ADDR     (d_addr),
    .D_RD       (d_rd),
    .D_WR       (d_wr),
    .RF_S       (rf_s),
    .RF_W_EN    (rf_w_en),
    .RF_RA_ADDR (ra_addr),
    .RF_RB_ADDR (rb_addr),
    .RF_W_ADDR  (w_addr),
    .ALU_S      (alu_s),
    .HALTED     (halted)
  );

  assign act = {pc_clr, pc_ld, pc_inc, pc_off, d_addr, d_rd, d_wr, rf_s, rf_w_en,
                ra_addr, rb_addr, w_addr, alu_s, halted};

  initial forever #5 clk = ~clk;

  function automatic out_t o_init();
    out_t o = '0;
    o.pc_clr = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fetch();
    out_t o = '0;
    o.pc_inc = 1'b1;
    return o;
  endfunction

  function automatic out_t o_dec(input logic [3:0] ra, input logic [3:0] rb);
    out_t o = '0;
    o.ra = ra;
    o.rb = rb;
    return o;
  endfunction

  function automatic out_t o_lda(input logic [7:0] a);
    out_t o = '0;
    o.d_rd   = 1'b1;
    o.d_addr = a;
    return o;
  endfunction

  function automatic out_t o_ldb(input logic [3:0] w);
    out_t o = '0;
    o.rf_s    = 1'b1;
    o.rf_w_en = 1'b1;
    o.wa      = w;
    return o;
  endfunction

  function automatic out_t o_st(input logic [7:0] a, input logic [3:0] r);
    out_t o = '0;
    o.d_wr   = 1'b1;
    o.d_addr = a;
    o.ra     = r;
    return o;
  endfunction

  function automatic out_t o_alu(input logic [2:0] s, input logic [3:0] w);
    out_t o = '0;
    o.rf_w_en = 1'b1;
    o.wa      = w;
    o.alu_s   = s;
    return o;
  endfunction

  function automatic out_t o_jmp(input logic [3:0] ra, input logic [7:0] off, input logic ld);
    out_t o = '0;
    o.ra     = ra;
    o.pc_off = off;
    o.pc_ld  = ld;
    return o;
  endfunction

  function automatic out_t o_halt();
    out_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic check(input out_t a, input out_t e, input string nm);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Called at a negedge with inputs already set; e is the output after the next posedge.
  task automatic cyc(input out_t e, input string nm);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) check(act, exp_q.pop_front(), nm_q.pop_front());
  end

  logic [15:0] alu_ins [4] = '{16'h3456, 16'h4123, 16'h5789, 16'h6ABC};
  logic [3:0]  alu_ra  [4] = '{4'h4, 4'h1, 4'h7, 4'hA};
  logic [3:0]  alu_rb  [4] = '{4'h5, 4'h2, 4'h8, 4'hB};
  logic [3:0]  alu_rd  [4] = '{4'h6, 4'h3, 4'h9, 4'hC};
  logic [2:0]  alu_sv  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    rst_n   = 1'b0;
    instr   = '0;
    mem_rdy = 1'b0;
    ra_zero = 1'b0;
    @(negedge clk);

    repeat (3) cyc(o_init(), "reset_hold");
    rst_n = 1'b1;
    cyc(o_init(), "init_after_release");
    cyc(o_fetch(), "first_fetch");

    // LOAD with two wait cycles; INSTR changes after capture to show IR holds
    instr = 16'h1A53;
    cyc(o_dec(4'hA, 4'h5), "load_decode");
    instr = 16'hFFFF;
    cyc(o_lda(8'hA5), "load_a_enter");
    cyc(o_lda(8'hA5), "load_wait1");
    cyc(o_lda(8'hA5), "load_wait2");
    mem_rdy = 1'b1;
    cyc(o_ldb(4'h3), "load_b");
    mem_rdy = 1'b0;
    cyc(o_fetch(), "load_done");

    // STORE with zero wait states
    instr   = 16'h2107;
    mem_rdy = 1'b1;
    cyc(o_dec(4'h1, 4'h0), "store_decode");
    cyc(o_st(8'h10, 4'h7), "store");
    cyc(o_fetch(), "store_done");
    mem_rdy = 1'b0;

    for (int i = 0; i < 4; i++) begin
      instr = alu_ins[i];
      cyc(o_dec(alu_ra[i], alu_rb[i]), "alu_decode");
      cyc(o_alu(alu_sv[i], alu_rd[i]), "alu_exec");
      cyc(o_fetch(), "alu_done");
    end

`ifdef CU_JPZ_EN
    for (int z = 1; z >= 0; z--) begin
      instr = 16'h72FE;
      cyc(o_dec(4'h2, 4'hF), "jpz_decode");
      ra_zero = 1'(z);
      cyc(o_jmp(4'h2, 8'hFE, 1'(z)), "jpz_jump");
      ra_zero = 1'b0;
      cyc(o_fetch(), "jpz_done");
    end
`else
    instr = 16'h72FE;
    cyc(o_dec(4'h2, 4'hF), "jpz_off_decode");
    cyc(o_fetch(), "jpz_off_noop");
`endif

    instr = 16'h9000;
    cyc(o_dec(4'h0, 4'h0), "undef9_decode");
    cyc(o_fetch(), "undef9_noop");
    instr = 16'h0ABC;
    cyc(o_dec(4'hA, 4'hB), "noop_decode");
    cyc(o_fetch(), "noop_done");

    // STORE stalled on MEM_RDY, then reset asserted mid-cycle
    instr = 16'h2355;
    cyc(o_dec(4'h3, 4'h5), "st2_decode");
    cyc(o_st(8'h35, 4'h5), "st2_enter");
    cyc(o_st(8'h35, 4'h5), "st2_wait");
    #2;
    rst_n = 1'b0;
    #1;
    check(act, o_init(), "reset_drops_dwr");
    @(negedge clk);
    cyc(o_init(), "reset_again");
    rst_n = 1'b1;
    cyc(o_init(), "init_again");
    cyc(o_fetch(), "fetch_again");

    instr = 16'hF000;
    cyc(o_dec(4'h0, 4'h0), "halt_decode");
    repeat (20) begin
      mem_rdy = 1'($urandom_range(0, 1));
      ra_zero = 1'($urandom_range(0, 1));
      instr   = 16'(($urandom_range(0, 15)) << 12);
      cyc(o_halt(), "halt_hold");
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
